// File: rtl/mem_stage_wbuf.sv
// ---------------------------------------------------------------------------
// mem_stage_wbuf
//   MEM-stage memory front end with a posted-write buffer in front of the
//   SRAM controller. Stores are posted into a FIFO and retire in one cycle
//   while the FIFO drains to SRAM in the background. Loads that match a
//   buffered address are forwarded from the youngest matching entry in the
//   same cycle. Load misses wait until the FIFO has fully drained, then issue
//   one SRAM read. ready low stalls the pipeline.
//
// Parameters
//   ADDR_W    byte address width (full-width compare)
//   DATA_W    data word width
//   WB_DEPTH  write-buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   mem_read      load request (level, held until ready)
//   mem_write     store request (level, held until ready); wins over mem_read
//   address       request address
//   data          store data
//   mem_result    load data, valid when ready & mem_read (combinational)
//   ready         request completes this cycle; 1 with no request (comb)
//   sram_read     registered backend read strobe, held until sram_ready
//   sram_write    registered backend write strobe, held until sram_ready
//   sram_address  registered backend address
//   sram_wdata    registered backend write data
//   sram_rdata    backend read data, valid with sram_ready
//   sram_ready    backend completion pulse
// ---------------------------------------------------------------------------
module mem_stage_wbuf #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] mem_result,
  output logic              ready,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(WB_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Write-buffer storage and control
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic wr_req;
  logic rd_req;
  logic full;
  logic push;
  logic pop;

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  scan_idx;

  // Next values for the registered backend interface
  logic              sram_read_d;
  logic              sram_write_d;
  logic [ADDR_W-1:0] sram_address_d;
  logic [DATA_W-1:0] sram_wdata_d;

  // A simultaneous read+write is a write; the read half is ignored.
  assign wr_req = mem_write;
  assign rd_req = mem_read & ~mem_write;
  assign full   = (count == DEPTH_CNT);
  // Admission uses the registered count only, so a same-edge pop never frees
  // a slot for a store that found the buffer full.
  assign push   = wr_req & ~full;
  assign pop    = (state == WR_BUSY) & sram_ready;

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int k = 0; k < int'(WB_DEPTH); k++) begin
      scan_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (wb_addr[scan_idx] == address)) begin
        hit      = 1'b1;
        hit_data = wb_data[scan_idx];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; buffered writes always go out before any read miss
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = WR_BUSY;
        end else if (rd_req && !hit) begin
          next_state = RD_BUSY;
        end
      end
      WR_BUSY: begin
        if (sram_ready) begin
          next_state = IDLE;
        end
      end
      RD_BUSY: begin
        if (sram_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM output logic: pipeline handshake plus next backend register values
  always_comb begin
    ready          = 1'b1;
    mem_result     = '0;
    sram_read_d    = 1'b0;
    sram_write_d   = 1'b0;
    sram_address_d = sram_address;
    sram_wdata_d   = sram_wdata;

    if (wr_req) begin
      ready = ~full;
    end else if (rd_req) begin
      if (hit) begin
        mem_result = hit_data;
      end else if ((state == RD_BUSY) && sram_ready) begin
        // Miss data passes straight through in the completion cycle
        mem_result = sram_rdata;
      end else begin
        ready = 1'b0;
      end
    end

    // Strobes follow the state being entered, so they drop on the same edge
    // the FSM returns to IDLE.
    case (next_state)
      WR_BUSY: begin
        sram_write_d   = 1'b1;
        sram_address_d = wb_addr[rd_ptr];
        sram_wdata_d   = wb_data[rd_ptr];
      end
      RD_BUSY: begin
        sram_read_d    = 1'b1;
        sram_address_d = address;
      end
      default: ;
    endcase
  end

  // Registered backend interface
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_read    <= 1'b0;
      sram_write   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
    end else begin
      sram_read    <= sram_read_d;
      sram_write   <= sram_write_d;
      sram_address <= sram_address_d;
      sram_wdata   <= sram_wdata_d;
    end
  end

  // FIFO pointers and occupancy; reset discards any unacked posted writes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr] <= address;
      wb_data[wr_ptr] <= data;
    end
  end

endmodule
